pipe_rca_n: RTL and testbench
=============================

PIPE_RCA_N -- requirements
Module: pipe_rca_n

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter BPS, default 4: bits added per pipeline stage.
REQ-003 Derived constant STAGES = WIDTH/BPS: number of adder stages.
REQ-004 clk  input  1  single clock; all registers update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts the operand beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in when adding; borrow-in when subtracting.
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result beat.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  raw carry out of the MSB.
REQ-016 ovf  output  1  signed two's-complement overflow.

Function
REQ-017 Effective operand: b_eff = sub ? ~b : b; carry into bit 0 = sub ? ~cin : cin, so sub=1 yields a-b-cin.
REQ-018 sum = (a + b_eff + carry-in) mod 2^WIDTH; cout = bit WIDTH of that addition.
REQ-019 ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
REQ-020 Stage k (0..STAGES-1) resolves bits [k*BPS +: BPS] using the carry registered from stage k-1 and passes the unresolved upper operand bits and the lower sum bits forward in registers.
REQ-021 Every stage register carries a valid bit; the final stage feeds an output register driving sum, cout, ovf and out_valid.
REQ-022 Global advance condition adv = !out_valid || out_ready; in_ready = adv (combinational).
REQ-023 A beat is accepted at a rising edge when in_valid && in_ready.
REQ-024 Latency: result of a beat accepted at edge E is on outputs with out_valid=1 after edge E+STAGES (E counted as edge 0).
REQ-025 Throughput: one beat per cycle while out_ready=1; no bubbles are inserted.
REQ-026 When adv=0 all stage registers and outputs hold; sum/cout/ovf remain stable while out_valid && !out_ready.
REQ-027 Bubbles (valid=0 slots) propagate like data; in_valid=0 at an accepted edge loads a bubble.
REQ-028 Result order equals acceptance order; no beat is dropped or duplicated.
REQ-029 out_valid && out_ready at the same edge as a new acceptance: both occur; pipeline shifts by one.
REQ-030 Illegal parameters (WIDTH mod BPS != 0, BPS < 1, WIDTH < 2) shall stop elaboration.
REQ-031 Degenerate BPS = WIDTH is legal: one adder stage, latency 1.

Reset
REQ-032 rst_n low clears all valid bits, data registers, sum, cout and ovf to 0 immediately, independent of clk.
REQ-033 Reset mid-operation discards all in-flight beats; none appears after release.
REQ-034 in_ready = 1 during and after reset (out_valid is 0).
REQ-035 First acceptance possible at the first rising edge after rst_n deasserts.

Structure
REQ-036 Shared package pipe_rca_pkg holds default WIDTH/BPS constants and the STAGES derivation function.
REQ-037 One sub-module rca_slice: combinational BPS-bit ripple adder (a, b, cin -> s, cout) built from the existing one-bit full adder, instantiated STAGES times.

Verification (WIDTH=16, BPS=4 unless stated)
REQ-038 Add a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 edges sum=0x0000, cout=1, ovf=0.
REQ-039 Sub a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, cout=1, ovf=1; a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0.
REQ-040 Back-to-back 8 beats a=i, b=0x1000*i, out_ready=1 -> 8 consecutive out_valid cycles, in order, latency 4.
REQ-041 out_ready=0 for 6 cycles while in_valid=1 -> in_ready falls once output is full, outputs hold stable, no loss after out_ready returns.
REQ-042 rst_n pulsed low with 3 beats in flight -> out_valid=0, sum=0 immediately; no stale result after release.
REQ-043 Parameter sweep WIDTH/BPS = 8/1, 8/8, 32/8 with 1000 random beats and random out_ready -> all results match reference model a+b_eff+carry-in.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
package pipe_rca_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_BPS   = 4;

    // Number of adder stages; guarded so an illegal BPS of zero cannot divide by zero.
    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned bps);
        return (bps == 0) ? 1 : width / bps;
    endfunction

    // Legal when every stage gets a full slice and there is a distinct sign bit.
    function automatic bit params_legal(input int unsigned width, input int unsigned bps);
        return (bps >= 1) && (width >= 2) && ((width % bps) == 0);
    endfunction

endpackage

// File: rtl/pipe_rca_if.sv
// Operand/result handshake bundle for pipe_rca_n.
interface pipe_rca_if import pipe_rca_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_rca_n_full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipe_rca_n_rca_slice.sv
// Combinational BPS-bit ripple-carry adder built from full_adder cells.
module rca_slice import pipe_rca_pkg::*; #(
    parameter int unsigned BPS = DEFAULT_BPS
) (
    input  logic [BPS-1:0] a,
    input  logic [BPS-1:0] b,
    input  logic           cin,
    output logic [BPS-1:0] s,
    output logic           cout
);
    logic [BPS:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < BPS; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[BPS];
endmodule

// File: rtl/pipe_rca_n.sv
// Pipelined add/subtract: STAGES ripple slices of BPS bits, one register per slice,
// followed by an output register. The whole pipe advances together when the output
// slot is empty or being drained.
//
// Each stage keeps its operands in a rotating word: the slice consumes the low BPS
// bits, and its sum bits are pushed in at the top while the word shifts right. After
// the last stage the A word therefore holds the complete sum in natural bit order.
module pipe_rca_n import pipe_rca_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned BPS   = DEFAULT_BPS
) (
    input logic      clk,
    input logic      rst_n,
    pipe_rca_if.slave bus
);
    localparam int unsigned STAGES = calc_stages(WIDTH, BPS);

    if (!params_legal(WIDTH, BPS)) begin : g_param_check
        $fatal(1, "pipe_rca_n: WIDTH must be >= 2 and a multiple of BPS >= 1");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;

    logic             st_valid [STAGES];
    logic [WIDTH-1:0] st_aw    [STAGES];
    logic [WIDTH-1:0] st_bw    [STAGES];
    logic             st_carry [STAGES];
    logic             st_ovf;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // Subtraction is a + ~b + ~borrow.
    assign b_eff  = bus.sub ? ~bus.b : bus.b;
    assign carry0 = bus.cin ^ bus.sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] aw_in;
        logic [WIDTH-1:0] bw_in;
        logic             c_in;
        logic [BPS-1:0]   s_slice;
        logic             c_slice;
        logic [WIDTH-1:0] aw_nx;

        if (k == 0) begin : g_first
            assign v_in  = bus.in_valid;
            assign aw_in = bus.a;
            assign bw_in = b_eff;
            assign c_in  = carry0;
        end else begin : g_chain
            assign v_in  = st_valid[k-1];
            assign aw_in = st_aw[k-1];
            assign bw_in = st_bw[k-1];
            assign c_in  = st_carry[k-1];
        end

        rca_slice #(
            .BPS (BPS)
        ) u_slice (
            .a    (aw_in[BPS-1:0]),
            .b    (bw_in[BPS-1:0]),
            .cin  (c_in),
            .s    (s_slice),
            .cout (c_slice)
        );

        if (STAGES == 1) begin : g_whole
            assign aw_nx = s_slice;
        end else begin : g_rotate
            assign aw_nx = {s_slice, aw_in[WIDTH-1:BPS]};
        end

        // Stage register: valid, rotated operands and the carry out of this slice.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_valid[k] <= 1'b0;
                st_aw[k]    <= '0;
                st_bw[k]    <= '0;
                st_carry[k] <= 1'b0;
            end else if (adv) begin
                st_valid[k] <= v_in;
                st_aw[k]    <= aw_nx;
                st_bw[k]    <= bw_in >> BPS;
                st_carry[k] <= c_slice;
            end
        end

        if (k == STAGES - 1) begin : g_last
            // In the last slice the low bits of the rotated words are the operand sign bits.
            logic ovf_nx;

            assign ovf_nx = (aw_in[BPS-1] == bw_in[BPS-1]) && (s_slice[BPS-1] != aw_in[BPS-1]);

            // Overflow flag travels alongside the final stage register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_ovf <= 1'b0;
                end else if (adv) begin
                    st_ovf <= ovf_nx;
                end
            end
        end
    end

    // Output register: takes the last stage on advance, holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= st_valid[STAGES-1];
            sum_q       <= st_aw[STAGES-1];
            cout_q      <= st_carry[STAGES-1];
            ovf_q       <= st_ovf;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_rca_n.sv
// Directed and randomized checks of pipe_rca_n against an arithmetic reference model.
module tb_pipe_rca_n;
    localparam int NSW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_rca_if #(.WIDTH(16)) m_if ();
    pipe_rca_n #(.WIDTH(16), .BPS(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

    // Sweep instances share 32-bit bench-side arrays so one loop can drive all of them.
    logic        s_iv  [NSW];
    logic [31:0] s_a   [NSW];
    logic [31:0] s_b   [NSW];
    logic        s_cin [NSW];
    logic        s_sub [NSW];
    logic        s_ordy[NSW];
    logic        o_irdy[NSW];
    logic        o_ov  [NSW];
    logic [31:0] o_sum [NSW];
    logic        o_cout[NSW];
    logic        o_ovf [NSW];
    int unsigned sw_w  [NSW] = '{8, 8, 32};

    pipe_rca_if #(.WIDTH(8))  sw0_if ();
    pipe_rca_if #(.WIDTH(8))  sw1_if ();
    pipe_rca_if #(.WIDTH(32)) sw2_if ();
    pipe_rca_n #(.WIDTH(8),  .BPS(1)) u_sw0 (.clk(clk), .rst_n(rst_n), .bus(sw0_if));
    pipe_rca_n #(.WIDTH(8),  .BPS(8)) u_sw1 (.clk(clk), .rst_n(rst_n), .bus(sw1_if));
    pipe_rca_n #(.WIDTH(32), .BPS(8)) u_sw2 (.clk(clk), .rst_n(rst_n), .bus(sw2_if));

    assign sw0_if.in_valid = s_iv[0];
    assign sw0_if.a        = s_a[0][7:0];
    assign sw0_if.b        = s_b[0][7:0];
    assign sw0_if.cin      = s_cin[0];
    assign sw0_if.sub      = s_sub[0];
    assign sw0_if.out_ready = s_ordy[0];
    assign o_irdy[0] = sw0_if.in_ready;
    assign o_ov[0]   = sw0_if.out_valid;
    assign o_sum[0]  = {24'd0, sw0_if.sum};
    assign o_cout[0] = sw0_if.cout;
    assign o_ovf[0]  = sw0_if.ovf;

    assign sw1_if.in_valid = s_iv[1];
    assign sw1_if.a        = s_a[1][7:0];
    assign sw1_if.b        = s_b[1][7:0];
    assign sw1_if.cin      = s_cin[1];
    assign sw1_if.sub      = s_sub[1];
    assign sw1_if.out_ready = s_ordy[1];
    assign o_irdy[1] = sw1_if.in_ready;
    assign o_ov[1]   = sw1_if.out_valid;
    assign o_sum[1]  = {24'd0, sw1_if.sum};
    assign o_cout[1] = sw1_if.cout;
    assign o_ovf[1]  = sw1_if.ovf;

    assign sw2_if.in_valid = s_iv[2];
    assign sw2_if.a        = s_a[2];
    assign sw2_if.b        = s_b[2];
    assign sw2_if.cin      = s_cin[2];
    assign sw2_if.sub      = s_sub[2];
    assign sw2_if.out_ready = s_ordy[2];
    assign o_irdy[2] = sw2_if.in_ready;
    assign o_ov[2]   = sw2_if.out_valid;
    assign o_sum[2]  = sw2_if.sum;
    assign o_cout[2] = sw2_if.cout;
    assign o_ovf[2]  = sw2_if.ovf;

    function automatic logic [63:0] pack(input logic ovf, input logic cout, input logic [31:0] sum);
        return {30'd0, ovf, cout, sum};
    endfunction

    // Reference: unsigned sum for sum/cout, signed-range test for overflow.
    function automatic logic [63:0] ref_model(input int unsigned w, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin,
                                              input logic sub);
        longint unsigned mask, half, ua, ub, cc, tot;
        longint          sa, sb, r;
        logic [63:0]     t;
        logic            ovf, cout;
        mask = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        ua   = {32'd0, a} & mask;
        ub   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        cc   = ((sub ? !cin : cin) == 1'b1) ? 64'd1 : 64'd0;
        tot  = ua + ub + cc;
        sa   = (ua >= half) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = (ub >= half) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        r    = sa + sb + longint'(cc);
        ovf  = (r >= longint'(half)) || (r < -longint'(half));
        cout = ((tot >> w) & 64'd1) != 64'd0;
        t    = tot & mask;
        return pack(ovf, cout, t[31:0]);
    endfunction

    function automatic logic [63:0] m_res();
        return pack(m_if.ovf, m_if.cout, {16'd0, m_if.sum});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        m_if.in_valid = v;
        m_if.a        = a;
        m_if.b        = b;
        m_if.cin      = cin;
        m_if.sub      = sub;
    endtask

    logic [63:0] exp_mem [NSW][64];
    int          wr [NSW];
    int          rd [NSW];
    int          sent [NSW];
    bit          done;

    initial begin
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        m_if.out_ready = 1'b1;
        for (int j = 0; j < NSW; j++) begin
            s_iv[j] = 1'b0; s_a[j] = '0; s_b[j] = '0; s_cin[j] = 1'b0; s_sub[j] = 1'b0;
            s_ordy[j] = 1'b1; wr[j] = 0; rd[j] = 0; sent[j] = 0;
        end

        // Asynchronous reset, observed before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check_bit("rst_out_valid", m_if.out_valid, 1'b0);
        check("rst_result", m_res(), 64'd0);
        check_bit("rst_in_ready", m_if.in_ready, 1'b1);

        // Add with full carry ripple; latency boundary at edge 4.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check_bit("add_early_valid", m_if.out_valid, 1'b0);
        end
        @(negedge clk);
        check_bit("add_valid", m_if.out_valid, 1'b1);
        check("add_result", m_res(), pack(1'b0, 1'b1, 32'h0000));

        // Two back-to-back subtractions.
        drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_bit("sub_early_valid", m_if.out_valid, 1'b0);
        @(negedge clk);
        check_bit("sub1_valid", m_if.out_valid, 1'b1);
        check("sub1_result", m_res(), pack(1'b1, 1'b1, 32'h7FFF));
        @(negedge clk);
        check_bit("sub2_valid", m_if.out_valid, 1'b1);
        check("sub2_result", m_res(), pack(1'b0, 1'b0, 32'hFFFE));
        @(negedge clk);
        check_bit("sub_drained", m_if.out_valid, 1'b0);

        // Eight beats back to back: results on consecutive cycles, in order.
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(1'b1, 16'(k), 16'(k * 4096), 1'b0, 1'b0);
            else       drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            @(negedge clk);
            if (k >= 4) begin
                check_bit("burst_valid", m_if.out_valid, 1'b1);
                check("burst_result", m_res(),
                      ref_model(16, 32'(k - 4), 32'((k - 4) * 4096), 1'b0, 1'b0));
            end else begin
                check_bit("burst_idle", m_if.out_valid, 1'b0);
            end
        end
        @(negedge clk);
        check_bit("burst_drained", m_if.out_valid, 1'b0);

        // Downstream stall for six edges with the source always offering.
        m_if.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 16'(256 + k), 16'(17 * k), 1'b0, 1'b0);
            @(negedge clk);
            if (k <= 3) begin
                check_bit("stall_fill_ready", m_if.in_ready, 1'b1);
                check_bit("stall_fill_valid", m_if.out_valid, 1'b0);
            end else begin
                check_bit("stall_full_ready", m_if.in_ready, 1'b0);
                check_bit("stall_hold_valid", m_if.out_valid, 1'b1);
                check("stall_hold_result", m_res(), ref_model(16, 32'd256, 32'd0, 1'b0, 1'b0));
            end
        end
        m_if.out_ready = 1'b1;
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                check_bit("stall_drain_valid", m_if.out_valid, 1'b1);
                check("stall_drain_result", m_res(),
                      ref_model(16, 32'(256 + k), 32'(17 * k), 1'b0, 1'b0));
            end else begin
                check_bit("stall_no_extra", m_if.out_valid, 1'b0);
            end
        end

        // Reset with one result on the output and three beats still in flight.
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
            else        drive(1'b1, 16'(k), 16'(k), 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_bit("prerst_valid", m_if.out_valid, 1'b1);
        check("prerst_result", m_res(), pack(1'b0, 1'b1, 32'hFFFE));
        m_if.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_bit("midrst_valid", m_if.out_valid, 1'b0);
        check("midrst_result", m_res(), 64'd0);
        check_bit("midrst_in_ready", m_if.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            if (k < 4) begin
                check_bit("postrst_no_stale", m_if.out_valid, 1'b0);
            end else begin
                check_bit("postrst_valid", m_if.out_valid, 1'b1);
                check("postrst_result", m_res(),
                      ref_model(16, 32'h1234, 32'h4321, 1'b1, 1'b0));
            end
        end

        // Randomized sweep over 8/1, 8/8 and 32/8 with random backpressure.
        done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            for (int j = 0; j < NSW; j++) begin
                if (o_ov[j]) begin
                    if (rd[j] < wr[j]) begin
                        check($sformatf("sweep%0d_result", j),
                              pack(o_ovf[j], o_cout[j], o_sum[j]), exp_mem[j][rd[j] % 64]);
                    end else begin
                        check_bit($sformatf("sweep%0d_unexpected_beat", j), o_ov[j], 1'b0);
                    end
                end
                s_ordy[j] = ($urandom_range(0, 3) != 0);
                if (o_ov[j] && s_ordy[j]) rd[j]++;
                s_iv[j]  = (sent[j] < 1000) && ($urandom_range(0, 3) != 0);
                s_a[j]   = $urandom;
                s_b[j]   = $urandom;
                s_cin[j] = 1'($urandom_range(0, 1));
                s_sub[j] = 1'($urandom_range(0, 1));
            end
            #1;
            done = 1'b1;
            for (int j = 0; j < NSW; j++) begin
                check_bit($sformatf("sweep%0d_in_ready", j), o_irdy[j], !o_ov[j] || s_ordy[j]);
                if (s_iv[j] && o_irdy[j]) begin
                    exp_mem[j][wr[j] % 64] = ref_model(sw_w[j], s_a[j], s_b[j], s_cin[j], s_sub[j]);
                    wr[j]++;
                    sent[j]++;
                end
                if (sent[j] < 1000 || rd[j] != wr[j]) done = 1'b0;
            end
        end
        for (int j = 0; j < NSW; j++) s_iv[j] = 1'b0;
        check_bit("sweep_completed", done, 1'b1);
        for (int j = 0; j < NSW; j++) begin
            check($sformatf("sweep%0d_delivered", j), 64'(rd[j]), 64'd1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
